// File: rtl/cc_tag_comparator.sv
// cc_tag_comparator: direct-mapped tag lookup with one-cycle hit/miss resolve,
// fill/invalidate forwarding into the compare stage, and saturating hit/miss counters.
module cc_tag_comparator #(
  parameter int TAG_W = 17,
  parameter int IDX_W = 9,
  parameter int OFS_W = 6,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hs_pulse_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic [IDX_W-1:0]       index_i,
  input  logic [OFS_W-1:0]       offset_i,
  output logic                   tag_sram_rden_o,
  output logic [IDX_W-1:0]       tag_sram_raddr_o,
  input  logic [TAG_W-1:0]       tag_sram_rdata_i,
  output logic                   tag_sram_wren_o,
  output logic [IDX_W-1:0]       tag_sram_waddr_o,
  output logic [TAG_W-1:0]       tag_sram_wdata_o,
  input  logic                   fill_valid_i,
  input  logic [IDX_W-1:0]       fill_index_i,
  input  logic [TAG_W-1:0]       fill_tag_i,
  input  logic                   inv_all_i,
  output logic                   hit_flag_fifo_wren_o,
  output logic                   hit_flag_fifo_wdata_o,
  output logic                   hit_data_fifo_wren_o,
  output logic [IDX_W+OFS_W-1:0] hit_data_fifo_wdata_o,
  output logic                   miss_addr_fifo_wren_o,
  output logic [31:0]            miss_addr_fifo_wdata_o,
  output logic                   miss_req_fifo_wren_o,
  output logic [31:0]            miss_req_fifo_wdata_o,
  output logic [CNT_W-1:0]       hit_cnt_o,
  output logic [CNT_W-1:0]       miss_cnt_o
);
  logic [(1<<IDX_W)-1:0] valid;
  logic                  s1_v;
  logic [TAG_W-1:0]      s1_tag;
  logic [IDX_W-1:0]      s1_index;
  logic [OFS_W-1:0]      s1_offset;
  logic                  f_v;
  logic [IDX_W-1:0]      f_index;
  logic [TAG_W-1:0]      f_tag;
  logic                  fill_now, fill_fwd, eff_valid, hit;
  logic [TAG_W-1:0]      eff_tag;

  assign tag_sram_rden_o  = hs_pulse_i & rst_n;
  assign tag_sram_raddr_o = index_i;
  assign tag_sram_wren_o  = fill_valid_i & rst_n;
  assign tag_sram_waddr_o = fill_index_i;
  assign tag_sram_wdata_o = fill_tag_i;

  // SRAM read data is stale for a fill written in the same or the compare cycle
  assign fill_now  = fill_valid_i && fill_index_i == s1_index;
  assign fill_fwd  = f_v && f_index == s1_index;
  assign eff_tag   = fill_now ? fill_tag_i : fill_fwd ? f_tag : tag_sram_rdata_i;
  assign eff_valid = (valid[s1_index] | fill_now | fill_fwd) & ~inv_all_i;
  assign hit       = s1_v & eff_valid & (eff_tag == s1_tag);

  assign hit_flag_fifo_wren_o   = s1_v;
  assign hit_flag_fifo_wdata_o  = hit;
  assign hit_data_fifo_wren_o   = hit;
  assign hit_data_fifo_wdata_o  = {s1_index, s1_offset};
  assign miss_addr_fifo_wren_o  = s1_v & ~hit;
  assign miss_addr_fifo_wdata_o = 32'({s1_tag, s1_index, s1_offset});
  assign miss_req_fifo_wren_o   = s1_v & ~hit;
  assign miss_req_fifo_wdata_o  = 32'({s1_tag, s1_index, {OFS_W{1'b0}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      s1_v       <= 1'b0;
      s1_tag     <= '0;
      s1_index   <= '0;
      s1_offset  <= '0;
      f_v        <= 1'b0;
      f_index    <= '0;
      f_tag      <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (inv_all_i) valid <= '0;
      else if (fill_valid_i) valid[fill_index_i] <= 1'b1;
      s1_v      <= hs_pulse_i;
      s1_tag    <= tag_i;
      s1_index  <= index_i;
      s1_offset <= offset_i;
      f_v       <= fill_valid_i & ~inv_all_i;
      f_index   <= fill_index_i;
      f_tag     <= fill_tag_i;
      if (hit && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
      if (miss_addr_fifo_wren_o && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cc_tag_comparator.sv
// tb_cc_tag_comparator: directed lookups with a queue-based scoreboard checked by an independent monitor.
module tb_cc_tag_comparator;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        hs = 0, fv = 0, inv = 0;
  logic [16:0] tag = 0, ftag = 0, rdata = 0;
  logic [8:0]  index = 0, fidx = 0;
  logic [5:0]  offset = 0;

  logic        rden, wren, flag_wren, flag, hd_wren, ma_wren, mr_wren;
  logic [8:0]  raddr, waddr;
  logic [16:0] wdata;
  logic [14:0] hd_wdata;
  logic [31:0] ma_wdata, mr_wdata, hit_cnt, miss_cnt;

  logic        s_rden, s_wren, s_flag_wren, s_flag, s_hd_wren, s_ma_wren, s_mr_wren;
  logic [8:0]  s_raddr, s_waddr;
  logic [16:0] s_wdata;
  logic [14:0] s_hd_wdata;
  logic [31:0] s_ma_wdata, s_mr_wdata;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  cc_tag_comparator dut (
    .clk(clk), .rst_n(rst_n), .hs_pulse_i(hs), .tag_i(tag), .index_i(index), .offset_i(offset),
    .tag_sram_rden_o(rden), .tag_sram_raddr_o(raddr), .tag_sram_rdata_i(rdata),
    .tag_sram_wren_o(wren), .tag_sram_waddr_o(waddr), .tag_sram_wdata_o(wdata),
    .fill_valid_i(fv), .fill_index_i(fidx), .fill_tag_i(ftag), .inv_all_i(inv),
    .hit_flag_fifo_wren_o(flag_wren), .hit_flag_fifo_wdata_o(flag),
    .hit_data_fifo_wren_o(hd_wren), .hit_data_fifo_wdata_o(hd_wdata),
    .miss_addr_fifo_wren_o(ma_wren), .miss_addr_fifo_wdata_o(ma_wdata),
    .miss_req_fifo_wren_o(mr_wren), .miss_req_fifo_wdata_o(mr_wdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  // narrow-counter copy sees the same traffic so saturation is reachable
  cc_tag_comparator #(.CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .hs_pulse_i(hs), .tag_i(tag), .index_i(index), .offset_i(offset),
    .tag_sram_rden_o(s_rden), .tag_sram_raddr_o(s_raddr), .tag_sram_rdata_i(rdata),
    .tag_sram_wren_o(s_wren), .tag_sram_waddr_o(s_waddr), .tag_sram_wdata_o(s_wdata),
    .fill_valid_i(fv), .fill_index_i(fidx), .fill_tag_i(ftag), .inv_all_i(inv),
    .hit_flag_fifo_wren_o(s_flag_wren), .hit_flag_fifo_wdata_o(s_flag),
    .hit_data_fifo_wren_o(s_hd_wren), .hit_data_fifo_wdata_o(s_hd_wdata),
    .miss_addr_fifo_wren_o(s_ma_wren), .miss_addr_fifo_wdata_o(s_ma_wdata),
    .miss_req_fifo_wren_o(s_mr_wren), .miss_req_fifo_wdata_o(s_mr_wdata),
    .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
  );

  logic [16:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
    if (rden) rdata <= mem[raddr];
  end

  typedef struct {int cyc; logic hit; logic [31:0] addr;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("push_cycle", cyc, e.cyc);
      chk("flag_wren", {31'b0, flag_wren}, 1);
      chk("flag", {31'b0, flag}, {31'b0, e.hit});
      chk("hit_push", {31'b0, hd_wren}, {31'b0, e.hit});
      chk("miss_addr_push", {31'b0, ma_wren}, {31'b0, !e.hit});
      chk("miss_req_push", {31'b0, mr_wren}, {31'b0, !e.hit});
      if (e.hit) chk("hit_data", {17'b0, hd_wdata}, {17'b0, e.addr[14:0]});
      else begin
        chk("miss_addr", ma_wdata, e.addr);
        chk("miss_req", mr_wdata, e.addr & 32'hFFFF_FFC0);
      end
    end else if (flag_wren | hd_wren | ma_wren | mr_wren)
      chk("unexpected_push", {28'b0, flag_wren, hd_wren, ma_wren, mr_wren}, 0);
  end

  task automatic step(input logic h, input logic [31:0] a, input logic f, input logic [8:0] fi,
                      input logic [16:0] ft, input logic iv, input logic exp_hit);
    @(posedge clk); #1;
    hs = h; {tag, index, offset} = a; fv = f; fidx = fi; ftag = ft; inv = iv;
    if (h) q.push_back('{cyc + 1, exp_hit, a});
    #1;
    if (h) begin
      chk("rden", {31'b0, rden}, 1);
      chk("raddr", {23'b0, raddr}, {23'b0, a[14:6]});
    end
    if (f) chk("sram_write", {14'b0, wren, waddr, wdata}, {14'b0, 1'b1, fi, ft});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] A = 32'h0001_2345;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_flag_wren", {31'b0, flag_wren}, 0);
    chk("rst_wren", {31'b0, wren}, 0);

    step(1, A, 0, 0, 0, 0, 0); idle(); idle();
    chk("miss_cnt_1", miss_cnt, 1);
    chk("hit_cnt_0", hit_cnt, 0);

    step(0, 0, 1, 9'h08D, 17'h2, 0, 0); idle();
    step(1, A, 0, 0, 0, 0, 1); idle(); idle();
    chk("hit_cnt_1", hit_cnt, 1);

    step(1, {17'h5, 9'h010, 6'h3}, 1, 9'h010, 17'h5, 0, 1); idle();
    step(1, {17'h5, 9'h011, 6'h0}, 0, 0, 0, 0, 1);
    step(0, 0, 1, 9'h011, 17'h5, 0, 0); idle();

    for (int i = 0; i < 512; i++) step(0, 0, 1, 9'(i), 17'h2, 0, 0);
    for (int i = 0; i < 512; i++) step(1, {17'h2, 9'(i), 6'(i)}, 0, 0, 0, 0, 1);
    idle();

    step(0, 0, 0, 0, 0, 1, 0);
    step(1, A, 0, 0, 0, 0, 0); idle();
    step(0, 0, 1, 9'h050, 17'h2, 0, 0);
    step(1, {17'h2, 9'h050, 6'h1}, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0); idle();
    step(0, 0, 1, 9'h020, 17'h2, 1, 0);
    step(1, {17'h2, 9'h020, 6'h0}, 0, 0, 0, 0, 0); idle();
    step(1, {17'h2, 9'h021, 6'h0}, 1, 9'h021, 17'h2, 1, 0); idle();

    step(0, 0, 1, 9'h08D, 17'h2, 0, 0);
    step(1, {17'h1FFFF, 9'h08D, 6'h2A}, 0, 0, 0, 0, 0); idle();
    step(1, A, 0, 0, 0, 0, 1); idle(); idle();
    chk("hit_cnt_total", hit_cnt, 516);
    chk("miss_cnt_total", miss_cnt, 6);
    chk("sat_hit_cnt", {30'b0, s_hit_cnt}, 3);
    chk("sat_miss_cnt", {30'b0, s_miss_cnt}, 3);

    @(posedge clk); #1;
    hs = 1; {tag, index, offset} = A;
    @(posedge clk); #1;
    hs = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) idle();
    chk("post_rst_hit_cnt", hit_cnt, 0);
    chk("post_rst_miss_cnt", miss_cnt, 0);
    chk("post_rst_sat_hit_cnt", {30'b0, s_hit_cnt}, 0);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
